// File: rtl/uart_tx_byte_path.sv
// Byte FIFO feeding an 8N1 UART serializer; bytes leave LSB-first on uart_tx.
// uart_tx is registered from the FSM state, so the line trails the state by one cycle.
module uart_tx_byte_path #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    fifo_wr_data,
  input  logic                          fifo_wr_en,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          tx_enable,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic                          overflow_err,
  input  logic                          err_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift_reg, shift_n;
  logic          line_n, busy_q, timer_done;

  assign fifo_full  = (fifo_count == DEPTH_C);
  assign fifo_empty = (fifo_count == '0);
  assign push       = fifo_wr_en && !fifo_full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fifo_wr_data;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (err_clear)                   overflow_err <= 1'b0;
      else if (fifo_wr_en && fifo_full) overflow_err <= 1'b1;
    end
  end

  assign timer_done = (timer == TIMER_LAST);

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_idx_n = bit_idx;
    shift_n   = shift_reg;
    pop       = 1'b0;
    line_n    = 1'b1;
    case (state)
      IDLE: begin
        if (tx_enable && !fifo_empty) begin
          pop       = 1'b1;
          shift_n   = mem[rd_ptr];
          timer_n   = '0;
          bit_idx_n = '0;
          state_n   = START;
        end
      end
      START: begin
        line_n = 1'b0;
        if (timer_done) begin
          timer_n = '0;
          state_n = DATA;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      DATA: begin
        line_n = shift_reg[0];
        if (timer_done) begin
          timer_n = '0;
          shift_n = {1'b0, shift_reg[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      STOP: begin
        line_n = 1'b1;
        if (timer_done) begin
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // busy_q covers the final stop-bit cycle still on the line after the FSM reaches IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_n;
      uart_tx   <= line_n;
      busy_q    <= (state != IDLE);
    end
  end

  assign tx_busy = busy_q || (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_byte_path.sv
// Directed bench for uart_tx_byte_path: CLKS_PER_BIT=4 main instance, CLKS_PER_BIT=2 stream instance.
module tb_uart_tx_byte_path;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0, tx_enable = 1'b0, err_clear = 1'b0;
  logic       fifo_full, fifo_empty, uart_tx, tx_busy, overflow_err;
  logic [3:0] fifo_count;

  logic [7:0] wr_data2 = '0;
  logic       wr_en2 = 1'b0, tx_enable2 = 1'b1, err_clear2 = 1'b0;
  logic       full2, empty2, uart_tx2, busy2, ovf2;
  logic [3:0] count2;

  int tests = 0, fails = 0, cyc = 0;
  logic [7:0] sb[$];
  logic [7:0] sb2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_byte_path #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .fifo_wr_data(wr_data), .fifo_wr_en(wr_en),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .tx_enable(tx_enable), .uart_tx(uart_tx), .tx_busy(tx_busy),
    .overflow_err(overflow_err), .err_clear(err_clear));

  uart_tx_byte_path #(.CLKS_PER_BIT(2), .FIFO_DEPTH(8)) dut2 (
    .clk(clk), .rst(rst), .fifo_wr_data(wr_data2), .fifo_wr_en(wr_en2),
    .fifo_full(full2), .fifo_empty(empty2), .fifo_count(count2),
    .tx_enable(tx_enable2), .uart_tx(uart_tx2), .tx_busy(busy2),
    .overflow_err(ovf2), .err_clear(err_clear2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  function automatic logic lineOf(input bit sel);
    return sel ? uart_tx2 : uart_tx;
  endfunction

  // Waits (bounded) for a start bit, then samples each bit near its middle.
  task automatic rxByte(input int cpb, input bit sel, output logic [7:0] b, output int fall_cyc);
    bit found = 1'b0;
    b = '0;
    fall_cyc = 0;
    for (int i = 0; i < 300; i++) begin
      if (lineOf(sel) == 1'b0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) begin
      checkOutput("rx_timeout", 0, 1);
      return;
    end
    fall_cyc = cyc;
    repeat (cpb / 2) tick();
    for (int k = 0; k < 8; k++) begin
      repeat (cpb) tick();
      b[k] = lineOf(sel);
    end
    repeat (cpb) tick();
    checkOutput("rx_stop", {31'd0, lineOf(sel)}, 1);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 500; i++) begin
      if (!tx_busy) return;
      tick();
    end
    checkOutput("idle_timeout", 0, 1);
  endtask

  initial begin
    logic [7:0] b, rx;
    logic       exp_bit;
    int         f, prev_f, min_c, max_c, pushed;

    // Reset state
    tick();
    tick();
    checkOutput("rst_uart_tx", uart_tx, 1);
    checkOutput("rst_full", fifo_full, 0);
    checkOutput("rst_empty", fifo_empty, 1);
    checkOutput("rst_count", fifo_count, 0);
    checkOutput("rst_busy", tx_busy, 0);
    checkOutput("rst_ovf", overflow_err, 0);
    rst = 1'b0;
    tx_enable = 1'b1;
    tick();

    // Test 1: single 0x5A frame with exact bit timing
    b = 8'h5A;
    applyStimulus(b);
    checkOutput("t1_count", fifo_count, 1);
    checkOutput("t1_busy", tx_busy, 1);
    tick();
    checkOutput("t1_prefall", uart_tx, 1);
    tick();
    for (int k = 0; k < 10; k++) begin
      exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      checkOutput($sformatf("t1_bit%0d", k), uart_tx, exp_bit);
      if (k < 9) repeat (4) tick();
    end
    repeat (3) tick();
    checkOutput("t1_busy_stop", tx_busy, 1);
    tick();
    checkOutput("t1_busy_done", tx_busy, 0);
    checkOutput("t1_idle_line", uart_tx, 1);

    // Test 2: back-to-back bytes, 41-cycle frame spacing
    fork
      begin
        logic [7:0] v[4] = '{8'h5A, 8'h00, 8'h20, 8'hC7};
        for (int i = 0; i < 4; i++) begin
          sb.push_back(v[i]);
          applyStimulus(v[i]);
        end
      end
      begin
        prev_f = 0;
        for (int i = 0; i < 4; i++) begin
          rxByte(4, 1'b0, rx, f);
          checkOutput($sformatf("t2_byte%0d", i), rx, sb.pop_front());
          if (i > 0) checkOutput($sformatf("t2_gap%0d", i), f - prev_f, 41);
          prev_f = f;
        end
      end
    join
    waitIdle();

    // Test 3: fill with transmitter disabled, overflow on 9th push
    tx_enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sb.push_back(8'h10 + 8'(i));
      applyStimulus(8'h10 + 8'(i));
    end
    checkOutput("t3_full", fifo_full, 1);
    checkOutput("t3_count8", fifo_count, 8);
    checkOutput("t3_ovf_pre", overflow_err, 0);
    checkOutput("t3_no_tx", uart_tx, 1);
    applyStimulus(8'hEE);
    checkOutput("t3_ovf_set", overflow_err, 1);
    checkOutput("t3_count_hold", fifo_count, 8);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checkOutput("t3_ovf_clear", overflow_err, 0);

    // Test 4: drain while refilling, pointers wrap, no loss
    tx_enable = 1'b1;
    min_c = 99;
    max_c = 0;
    fork
      begin
        pushed = 0;
        while (pushed < 8) begin
          if (fifo_count < min_c) min_c = fifo_count;
          if (fifo_count > max_c) max_c = fifo_count;
          if (!fifo_full) begin
            wr_en   = 1'b1;
            wr_data = 8'h18 + 8'(pushed);
            sb.push_back(wr_data);
            pushed++;
          end else begin
            wr_en = 1'b0;
          end
          tick();
        end
        wr_en = 1'b0;
      end
      begin
        for (int i = 0; i < 16; i++) begin
          rxByte(4, 1'b0, rx, f);
          checkOutput($sformatf("t4_byte%0d", i), rx, sb.pop_front());
        end
      end
    join
    checkOutput("t4_min_count", min_c, 7);
    checkOutput("t4_max_count", max_c, 8);
    checkOutput("t4_no_ovf", overflow_err, 0);
    waitIdle();

    // Test 5: reset during data bit 3, then a clean frame
    applyStimulus(8'hA5);
    applyStimulus(8'h3C);
    repeat (18) tick();
    checkOutput("t5_bit3_low", uart_tx, 0);
    checkOutput("t5_count_pre", fifo_count, 1);
    rst = 1'b1;
    tick();
    checkOutput("t5_rst_line", uart_tx, 1);
    checkOutput("t5_rst_count", fifo_count, 0);
    checkOutput("t5_rst_busy", tx_busy, 0);
    rst = 1'b0;
    tick();
    fork
      applyStimulus(8'h81);
      begin
        rxByte(4, 1'b0, rx, f);
        checkOutput("t5_after_rst", rx, 8'h81);
      end
    join

    // Test 6: random 64-byte stream at CLKS_PER_BIT=2
    fork
      begin
        int n = 0;
        while (n < 64) begin
          if (!full2) begin
            wr_en2   = 1'b1;
            wr_data2 = 8'($urandom_range(0, 255));
            sb2.push_back(wr_data2);
            n++;
          end else begin
            wr_en2 = 1'b0;
          end
          tick();
        end
        wr_en2 = 1'b0;
      end
      begin
        for (int i = 0; i < 64; i++) begin
          rxByte(2, 1'b1, rx, f);
          checkOutput($sformatf("t6_byte%0d", i), rx, sb2.pop_front());
        end
      end
    join
    checkOutput("t6_no_ovf", ovf2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
